// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage restoring divider: FSM codes, handshake
// levels and the ALU opcodes that start a divide.
package ex_div_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam int DoubleRegBus = 64;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage, one quotient bit per clock.
// Optional by_zero_o flag enabled with macro EX_DIV_BYZERO_FLAG_EN.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
`ifdef EX_DIV_BYZERO_FLAG_EN
  output logic                by_zero_o,
`endif
  output logic                ready_o
);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*DATA_W:0] r_work;
  logic [DATA_W-1:0] r_divisor;
  logic              r_signed;
  logic              r_neg1;
  logic              r_neg2;
  logic              r_by_zero;

  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_rem;

  assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Partial remainder window is 33 bits wide: a shifted remainder of an
  // unsigned 32-bit divisor can need the extra bit.
  assign w_diff = r_work[2*DATA_W:DATA_W] - {1'b0, r_divisor};

  assign w_quo = (r_signed && (r_neg1 ^ r_neg2)) ? -r_work[DATA_W-1:0] : r_work[DATA_W-1:0];
  assign w_rem = (r_signed && r_neg1) ? -r_work[2*DATA_W:DATA_W+1] : r_work[2*DATA_W:DATA_W+1];

`ifdef EX_DIV_BYZERO_FLAG_EN
  assign by_zero_o = r_by_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_by_zero <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= DivByZero;
            end else begin
              r_state   <= DivOn;
              r_cnt     <= '0;
              r_work    <= {{DATA_W{1'b0}}, w_abs1, 1'b0};
              r_divisor <= w_abs2;
              r_signed  <= signed_div_i;
              r_neg1    <= signed_div_i & opdata1_i[DATA_W-1];
              r_neg2    <= signed_div_i & opdata2_i[DATA_W-1];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            r_state <= DivFree;
          end else begin
            r_state   <= DivEnd;
            r_work    <= '0;
            r_by_zero <= 1'b1;
            result_o  <= '0;
            ready_o   <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            r_state <= DivFree;
          end else if (r_cnt != CNT_W'(DATA_W)) begin
            if (w_diff[DATA_W])
              r_work <= {r_work[2*DATA_W-1:0], 1'b0};
            else
              r_work <= {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state  <= DivEnd;
            result_o <= {w_rem, w_quo};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          // EX keeps start_i high while stalled, so the result must hold.
          if (annul_i || start_i == DivStop) begin
            r_state   <= DivFree;
            r_by_zero <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div; covers by_zero_o when
// EX_DIV_BYZERO_FLAG_EN is defined.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef EX_DIV_BYZERO_FLAG_EN
  logic        by_zero_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
`ifdef EX_DIV_BYZERO_FLAG_EN
    .by_zero_o    (by_zero_o),
`endif
    .ready_o      (ready_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    tick(); tick();
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
    checks++;
    if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
`ifdef EX_DIV_BYZERO_FLAG_EN
    checks++;
    if (by_zero_o !== 1'b0) begin errors++; $display("FAIL reset_by_zero got %b want 0", by_zero_o); end
`endif
    rst = 1'b0;
    tick();
  endtask

  // Start one op, disturb operands after the start edge, expect ready_o after edge lat.
  task automatic test_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input int hold, input logic exp_bz);
    logic early;
    early = 1'b0;
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == 1) begin opdata1_i = ~a; opdata2_i = b + 32'd1; signed_div_i = ~sgn; end
      if (k < lat && ready_o !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL %s_early_ready got 1 before edge %0d want 0", name, lat); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, ready_o); end
    checks++;
    if (result_o !== exp) begin errors++; $display("FAIL %s_result got %h want %h", name, result_o, exp); end
`ifdef EX_DIV_BYZERO_FLAG_EN
    checks++;
    if (by_zero_o !== exp_bz) begin errors++; $display("FAIL %s_by_zero got %b want %b", name, by_zero_o, exp_bz); end
`else
    if (exp_bz) checks += 0;
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== exp) begin
        errors++; $display("FAIL %s_hold%0d got ready=%b result=%h want ready=1 result=%h", name, h, ready_o, result_o, exp);
      end
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL %s_release got ready=%b result=%h want ready=0 result=0", name, ready_o, result_o);
    end
`ifdef EX_DIV_BYZERO_FLAG_EN
    checks++;
    if (by_zero_o !== 1'b0) begin errors++; $display("FAIL %s_by_zero_clear got %b want 0", name, by_zero_o); end
`endif
  endtask

  task automatic test_annul();
    logic seen;
    seen = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL annul_ready got 1 want 0 after annul"); end
    test_op("annul_then_100d7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic seen;
    seen = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
    for (int k = 0; k < 21; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL mid_reset got ready=%b result=%h want ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_reset_idle got ready=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_op("udiv_7d2",      1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 34, 5, 1'b0);
    test_op("sdiv_m7d2",     1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b0);
    test_op("udiv_maxd16",   1'b0, 32'hFFFFFFFF, 32'h10,       64'h0000000F_0FFFFFFF, 34, 0, 1'b0);
    test_op("sdiv_minm1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 0, 1'b0);
    test_op("div_by_zero",   1'b0, 32'd5,        32'd0,        64'h0,                  2, 2, 1'b1);
    test_annul();
    test_mid_reset();
    test_op("after_reset",   1'b1, 32'd20,       32'hFFFFFFFA, 64'h00000002_FFFFFFFD, 34, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle 32-bit integer divider attached to the EX stage, directly downstream of the ID/EX pipeline register.
- EX starts it when the latched aluop is DIV/DIVU, feeding it the EX operands reg1 and reg2.
- EX holds stallreq high until ready_o rises. The resulting stall vector freezes PC/IF/ID/EX for the duration.
- Restoring algorithm, one quotient bit per clock. Produces {remainder, quotient} for the HI/LO write.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W bits wide.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset (`RstEnable); sampled on posedge clk only.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  `DivStart/`DivStop; EX holds it high until it sees ready_o.
- annul_i  in  1  abort the current operation (flush).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  `DivResultReady while the result is valid.

Behaviour:
- Reset: all outputs and internal state are cleared. State = DIV_FREE, cnt = 0, dividend register = 0, result_o = 0, ready_o = 0.
- States and transitions:
  - DIV_FREE, start_i=1 and annul_i=0, opdata2_i==0 -> DIV_BY_ZERO.
  - DIV_FREE, start_i=1 and annul_i=0, opdata2_i!=0 -> DIV_ON. On this edge: latch |dividend| and |divisor| (absolute values only when signed_div_i=1), latch signed_div_i and both operand signs, cnt=0, 65-bit work register = {32'b0, |dividend|, 1'b0}.
  - DIV_FREE, start_i=0 or annul_i=1: stay in DIV_FREE.
  - DIV_BY_ZERO: -> DIV_END on the next edge with the work register zeroed; result_o = 0.
  - DIV_ON, annul_i=1: -> DIV_FREE immediately. Partial state is discarded and ready_o stays 0.
  - DIV_ON, annul_i=0, cnt<32: one iteration per edge.
    - diff = work[64:32] - {1'b0, divisor}.
    - diff negative: work <<= 1.
    - otherwise: work = {diff[31:0], work[31:0], 1'b1}, then shifted per the standard restoring layout.
    - cnt++.
  - DIV_ON, cnt==32: -> DIV_END.
    - Quotient is negated when signed and operand signs differ.
    - Remainder is negated when signed and the dividend is negative.
    - result_o = {rem, quo}; ready_o = 1.
  - DIV_END, start_i=0: -> DIV_FREE; ready_o = 0, result_o = 0.
  - DIV_END, start_i=1: hold; result_o and ready_o are stable.
- Latency: the start edge is edge 1. Normal ops assert ready_o after edge 34; divide-by-zero asserts it after edge 2.
- Operands are sampled only on the start edge. Changes afterwards are ignored.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- When stall[3] is held, EX keeps start_i high, so DIV_END holds the result.
- annul_i in DIV_BY_ZERO or DIV_END: -> DIV_FREE, outputs cleared.
- rst has priority over every other input in every state.

Optional Feature:
- Macro: EX_DIV_BYZERO_FLAG_EN.
- Defined: adds output by_zero_o (1 bit). It is set with ready_o when the path went through DIV_BY_ZERO, cleared whenever ready_o clears, and reset to 0.
- Undefined: no such port; divide-by-zero is indistinguishable from other ops except that it returns result 0.

Decomposition:
- Constants go in define.v:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit state codes).
  - DivResultReady, DivResultNotReady, DivStart, DivStop.
  - EXE_DIV_OP and EXE_DIVU_OP.
  - DoubleRegBus.
- No sub-module: the single restoring step is an inline subtract. The FSM plus datapath fits in one module (~150-200 lines).

Test Plan:
- Unsigned, 7 / 2, start held: ready_o rises after edge 34; result_o = 64'h00000001_00000003; ready_o falls one edge after start_i drops.
- Signed, 0xFFFFFFF9 (-7) / 2: result_o = 64'hFFFFFFFF_FFFFFFFD.
- Unsigned, 0xFFFFFFFF / 0x10: result_o = 64'h0000000F_0FFFFFFF. Signed 0x80000000 / 0xFFFFFFFF: result_o = 64'h00000000_80000000.
- Divide by zero, 5 / 0: ready_o after edge 2, result_o = 0. by_zero_o = 1 only when EX_DIV_BYZERO_FLAG_EN is defined.
- annul_i pulsed at iteration 10: state returns to DIV_FREE, ready_o never asserts. Then 100 / 7 unsigned: result_o = 64'h00000002_0000000E after 34 edges.
- rst asserted at iteration 20: next edge ready_o = 0, result_o = 0. start_i held in DIV_END for 5 cycles: result_o stable, ready_o high throughout.
